// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial frame levels.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses bit_done on the last cycle of every CLKS_PER_BIT-cycle bit while enabled.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transmitter_module.sv
// UART 8N1 transmitter: latches data_in on an accepted tx_start and shifts it out LSB-first on tx_out.
module transmitter_module
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_start,
    output logic                 tx_out,
    output logic                 tx_busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_e            state_q,   state_d;
    logic                 tx_out_q,  tx_out_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 bit_done;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q != IDLE),
        .bit_done(bit_done)
    );

    assign tx_out  = tx_out_q;
    assign tx_busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        tx_out_d  = tx_out_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                tx_out_d = IDLE_LVL;
                if (tx_start) begin
                    state_d   = START;
                    tx_out_d  = START_BIT;
                    shift_d   = data_in;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d  = STOP;
                        tx_out_d = STOP_BIT;
                    end else begin
                        // Shift first so the next line bit is always bit 0 of the register.
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_d[0];
                    end
                end
            end
            STOP: begin
                tx_out_d = STOP_BIT;
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_out_q  <= IDLE_LVL;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_out_q  <= tx_out_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_transmitter_module.sv
// Directed bench for transmitter_module at CLKS_PER_BIT=1 (dut1) and CLKS_PER_BIT=4 (dut4).
module tb_transmitter_module;

    logic       clk;
    logic       reset;
    logic [7:0] data1, data4;
    logic       start1, start4;
    logic       out1, out4;
    logic       busy1, busy4;
    int         total;
    int         bad;

    transmitter_module #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .data_in(data1), .tx_start(start1),
        .tx_out(out1), .tx_busy(busy1)
    );

    transmitter_module #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
        .clk(clk), .reset(reset), .data_in(data4), .tx_start(start4),
        .tx_out(out4), .tx_busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the accepting edge (k=0 is the start bit's first cycle).
    function automatic logic exp_bit(input logic [7:0] d, input int c, input int k);
        int b;
        b = k / c;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v; else start4 = v;
    endtask

    task automatic set_data(input int sel, input logic [7:0] v);
        if (sel == 0) data1 = v; else data4 = v;
    endtask

    // Caller sets data/start beforehand; this ticks through the whole frame checking every cycle.
    task automatic frame(input int sel, input logic [7:0] d, input int c, input int drop_at,
                         input int poke_at, input logic [7:0] poke_data, input logic poke_start,
                         input string tag);
        for (int k = 0; k < 10 * c; k++) begin
            tick();
            chk($sformatf("%s_out_k%0d", tag, k), (sel == 0) ? out1 : out4, exp_bit(d, c, k));
            chk($sformatf("%s_busy_k%0d", tag, k), (sel == 0) ? busy1 : busy4, 1'b1);
            if (k == drop_at) set_start(sel, 1'b0);
            if (k == poke_at) begin
                set_data(sel, poke_data);
                set_start(sel, poke_start);
            end
            if (k == poke_at + 1 && k > drop_at) set_start(sel, 1'b0);
        end
    endtask

    task automatic idle_chk(input int sel, input string tag);
        chk({tag, "_out"},  (sel == 0) ? out1 : out4,   1'b1);
        chk({tag, "_busy"}, (sel == 0) ? busy1 : busy4, 1'b0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        data1  = 8'h00;
        data4  = 8'h00;
        start1 = 1'b1;
        start4 = 1'b1;

        // 1. reset held with tx_start high: no frame may start
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk(0, $sformatf("rst1_c%0d", i));
            idle_chk(1, $sformatf("rst4_c%0d", i));
        end
        reset  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        tick();
        idle_chk(0, "post_rst1");
        idle_chk(1, "post_rst4");

        // 2. single pulsed frame 8'hAA
        data1  = 8'hAA;
        start1 = 1'b1;
        frame(0, 8'hAA, 1, 0, -1, 8'h00, 1'b0, "single");
        tick();
        idle_chk(0, "single_idle");

        // 3. tx_start held: back-to-back frames, second re-samples data_in (changed mid first frame)
        data1  = 8'hAA;
        start1 = 1'b1;
        frame(0, 8'hAA, 1, 99, 1, 8'h3C, 1'b1, "b2b_f1");
        tick();
        idle_chk(0, "b2b_gap");
        frame(0, 8'h3C, 1, 5, -1, 8'h00, 1'b0, "b2b_f2");
        tick();
        idle_chk(0, "b2b_end");

        // 4. CLKS_PER_BIT=4, data 8'h01, 40-cycle frame
        data4  = 8'h01;
        start4 = 1'b1;
        frame(1, 8'h01, 4, 0, -1, 8'h00, 1'b0, "c4");
        tick();
        idle_chk(1, "c4_idle");

        // 5. data_in change and tx_start pulse mid-frame are ignored
        data1  = 8'h5A;
        start1 = 1'b1;
        frame(0, 8'h5A, 1, 0, 4, 8'hFF, 1'b1, "ign");
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk(0, $sformatf("ign_idle%0d", i));
        end

        // 6. reset during DATA bit 3 aborts the frame; next request is clean
        data1  = 8'hC3;
        start1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("abort_out_k%0d", k), out1, exp_bit(8'hC3, 1, k));
            if (k == 0) start1 = 1'b0;
        end
        reset = 1'b1;
        tick();
        idle_chk(0, "abort_rst");
        reset = 1'b0;
        tick();
        idle_chk(0, "abort_idle");
        data1  = 8'h96;
        start1 = 1'b1;
        frame(0, 8'h96, 1, 0, -1, 8'h00, 1'b0, "clean");
        tick();
        idle_chk(0, "clean_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
